// File: rtl/my_ws2812_pkg.sv
// Shared WS2812 definitions: base timing at 100 MHz, GRB bit order, receiver states.
// Every timing constant here is divided by the instance's CLK_SCALE.
package my_ws2812_pkg;

  localparam int T_BIT_BASE     = 120;
  localparam int T0_HI_BASE     = 30;
  localparam int T1_HI_BASE     = 90;
  localparam int T_RES_BASE     = 6000;
  localparam int T_THR_BASE     = 60;
  localparam int T_HI_MAX_BASE  = 110;
  localparam int T_RST_DET_BASE = 3000;

  // Colour word layout: green goes out first, so it occupies the MSB byte.
  localparam int PIX_BITS = 24;
  localparam int G_LSB    = 16;
  localparam int R_LSB    = 8;
  localparam int B_LSB    = 0;

  typedef enum logic [1:0] {
    S_ARM,
    S_WAIT,
    S_HIGH,
    S_LOW
  } rx_state_t;

  function automatic logic [PIX_BITS-1:0] grb(input logic [7:0] g, input logic [7:0] r,
                                              input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/my_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
// Used on any asynchronous single-bit input.
module my_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/my_ws2812_rx.sv
// WS2812 line decoder: measures high-pulse widths, assembles GRB pixels,
// and reports the pixel index, the end of each frame, and protocol errors.
module my_ws2812_rx
  import my_ws2812_pkg::*;
#(
  parameter int CLK_SCALE = 1,
  parameter int CNT_LEDS  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic        pix_valid,
  output logic [5:0]  pix_addr,
  output logic [23:0] pix_color,
  output logic        frame_done,
  output logic        err
);

  localparam int T_THR     = T_THR_BASE / CLK_SCALE;
  localparam int T_HI_MAX  = T_HI_MAX_BASE / CLK_SCALE;
  localparam int T_RST_DET = T_RST_DET_BASE / CLK_SCALE;
  localparam int CW        = $clog2(T_RST_DET + 1);

  localparam logic [CW-1:0] C_THR    = CW'(T_THR);
  localparam logic [CW-1:0] C_HI_MAX = CW'(T_HI_MAX);
  localparam logic [CW-1:0] C_GAP    = CW'(T_RST_DET - 1);
  localparam logic [CW-1:0] C_SAT    = CW'(T_RST_DET);
  localparam logic [6:0]    C_LEDS   = 7'(CNT_LEDS);
  localparam logic [4:0]    C_LAST   = 5'(PIX_BITS - 1);

  logic din_s, din_d, rise, fall, bit_in;
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [22:0] shreg, shreg_n;
  logic [4:0]  bitcnt, bitcnt_n;
  logic [6:0]  pix_cnt, pix_cnt_n;
  logic        ovf, ovf_n;
  logic        valid_n, done_n, err_n;
  logic [5:0]  addr_n;
  logic [23:0] color_n;

  my_sync2 u_sync (.clk(clk), .rst(rst), .d(din), .q(din_s));

  assign rise    = din_s & ~din_d;
  assign fall    = ~din_s & din_d;
  assign bit_in  = (cnt >= C_THR);
  assign cnt_inc = (cnt == C_SAT) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_d      <= 1'b0;
      state      <= S_ARM;
      cnt        <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
      pix_cnt    <= '0;
      ovf        <= 1'b0;
      pix_valid  <= 1'b0;
      pix_addr   <= '0;
      pix_color  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      din_d      <= din_s;
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      pix_cnt    <= pix_cnt_n;
      ovf        <= ovf_n;
      pix_valid  <= valid_n;
      pix_addr   <= addr_n;
      pix_color  <= color_n;
      frame_done <= done_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    pix_cnt_n = pix_cnt;
    ovf_n     = ovf;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    addr_n    = pix_addr;
    color_n   = pix_color;
    case (state)
      // Nothing is decoded until a full reset gap has been seen on the line.
      S_ARM: begin
        if (din_s) begin
          cnt_n = '0;
        end else if (cnt == C_GAP) begin
          state_n   = S_WAIT;
          bitcnt_n  = '0;
          pix_cnt_n = '0;
          ovf_n     = 1'b0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT: begin
        if (rise) begin
          cnt_n   = CW'(1);
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt > C_HI_MAX) begin
          err_n    = 1'b1;
          bitcnt_n = '0;
          cnt_n    = '0;
          state_n  = S_ARM;
        end else if (fall) begin
          shreg_n = {shreg[21:0], bit_in};
          cnt_n   = CW'(1);
          state_n = S_LOW;
          if (bitcnt == C_LAST) begin
            bitcnt_n = '0;
            // Pixels beyond the frame length flag one error and are dropped.
            if (pix_cnt == C_LEDS) begin
              if (!ovf) begin
                err_n = 1'b1;
                ovf_n = 1'b1;
              end
            end else begin
              valid_n   = 1'b1;
              addr_n    = pix_cnt[5:0];
              color_n   = {shreg, bit_in};
              pix_cnt_n = pix_cnt + 7'd1;
            end
          end else begin
            bitcnt_n = bitcnt + 5'd1;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_LOW: begin
        if (rise) begin
          cnt_n   = CW'(1);
          state_n = S_HIGH;
        end else if (cnt == C_GAP) begin
          done_n    = 1'b1;
          err_n     = (bitcnt != 5'd0);
          bitcnt_n  = '0;
          pix_cnt_n = '0;
          ovf_n     = 1'b0;
          state_n   = S_WAIT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = S_ARM;
    endcase
  end

endmodule

// File: tb/tb_my_ws2812_rx.sv
// Self-checking bench for my_ws2812_rx: directed threshold/error/reset sequences
// plus random frames scored against a bit-list model of the protocol.
module tb_my_ws2812_rx;

  localparam int LEDS    = 4;
  localparam int RST_DET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        pix_valid, frame_done, err;
  logic [5:0]  pix_addr;
  logic [23:0] pix_color;

  my_ws2812_rx #(.CLK_SCALE(1), .CNT_LEDS(LEDS)) dut (
    .clk(clk), .rst(rst), .din(din), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_color(pix_color), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  // Output monitor
  typedef struct {
    int          cyc;
    logic [5:0]  addr;
    logic [23:0] color;
  } pix_t;

  pix_t got_q[$];
  int n_done, n_err, n_both, n_pv_err, done_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) got_q.push_back(pix_t'{cyc, pix_addr, pix_color});
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (err) n_err++;
      if (err && frame_done) n_both++;
      if (err && pix_valid) n_pv_err++;
    end
  end

  // Stimulus and reference record: intended bit values and pixel-ending fall times
  bit sent_bits[$];
  int fall_q[$];
  int last_fall_cyc;

  task automatic clear_mon();
    got_q.delete();
    sent_bits.delete();
    fall_q.delete();
    n_done = 0; n_err = 0; n_both = 0; n_pv_err = 0; done_cyc = 0;
  endtask

  task automatic hold(input logic lvl, input int n);
    din = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    hold(1'b1, hi);
    last_fall_cyc = cyc;
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    pulse(hi, lo);
    sent_bits.push_back(b);
    if (sent_bits.size() % 24 == 0) fall_q.push_back(last_fall_cyc);
  endtask

  task automatic send_word_nom(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i], w[i] ? 90 : 30, w[i] ? 30 : 90);
  endtask

  task automatic send_word_fast(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i], w[i] ? 66 : 12, 3);
  endtask

  task automatic send_bit_rand(input bit b);
    int hi;
    hi = b ? int'($urandom_range(110, 60)) : int'($urandom_range(59, 1));
    send_bit(b, hi, int'($urandom_range(6, 1)));
  endtask

  task automatic gap();
    hold(1'b0, RST_DET + 5);
  endtask

  // Model: bits group into 24-bit words MSB first; words past LEDS are dropped with
  // one error; a leftover partial word at the gap adds an error alongside frame_done.
  task automatic check_frame(input string tag);
    int nb, words, left, nexp, exp_err;
    logic [23:0] w;
    nb      = sent_bits.size();
    words   = nb / 24;
    left    = nb % 24;
    nexp    = (words < LEDS) ? words : LEDS;
    exp_err = ((words > LEDS) ? 1 : 0) + ((left != 0) ? 1 : 0);
    chk($sformatf("%s pix_count", tag), got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++) begin
      w = '0;
      for (int k = 0; k < 24; k++) w = {w[22:0], sent_bits[i*24+k]};
      chk($sformatf("%s pix%0d addr", tag, i), got_q[i].addr, i);
      chk($sformatf("%s pix%0d color", tag, i), got_q[i].color, w);
      chk($sformatf("%s pix%0d latency", tag, i), got_q[i].cyc, fall_q[i] + 3);
    end
    chk($sformatf("%s frame_done", tag), n_done, 1);
    chk($sformatf("%s err", tag), n_err, exp_err);
    chk($sformatf("%s pix_valid_with_err", tag), n_pv_err, 0);
    if (left != 0) chk($sformatf("%s err_with_done", tag), n_both, 1);
    if (n_done == 1)
      chk($sformatf("%s done_time", tag), done_cyc, last_fall_cyc + 3 + RST_DET - 1);
  endtask

  typedef struct {
    int   hi;
    logic bit_exp;
  } thr_vec_t;

  thr_vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] c;
    int npx, extra;

    tbl[0] = '{1, 1'b0};   tbl[1] = '{29, 1'b0};  tbl[2] = '{30, 1'b0};  tbl[3] = '{59, 1'b0};
    tbl[4] = '{60, 1'b1};  tbl[5] = '{61, 1'b1};  tbl[6] = '{90, 1'b1};  tbl[7] = '{110, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst pix_valid", pix_valid, 0);
    chk("rst pix_addr", pix_addr, 0);
    chk("rst pix_color", pix_color, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    gap();
    chk("arm no events", n_done + n_err + got_q.size(), 0);

    // Loopback-style frame at nominal widths
    clear_mon();
    for (int i = 0; i < LEDS; i++) begin
      c = {8'(i), ~8'(i), 8'hA5};
      send_word_nom(c);
    end
    gap();
    check_frame("loopback");
    chk("color hold", pix_color, {8'(LEDS - 1), ~8'(LEDS - 1), 8'hA5});
    chk("addr hold", pix_addr, LEDS - 1);

    // Threshold table: bit k uses tbl[k%8], period 120
    clear_mon();
    for (int k = 0; k < 24; k++) send_bit(tbl[k%8].bit_exp, tbl[k%8].hi, 120 - tbl[k%8].hi);
    gap();
    check_frame("thr");
    for (int k = 0; k < 8; k++)
      if (got_q.size() > 0)
        chk($sformatf("thr hi=%0d", tbl[k].hi), got_q[0].color[23-k], tbl[k].bit_exp);

    // Over-long high pulse, then a frame without gap (ignored), then gap + good frame
    clear_mon();
    for (int k = 0; k < 5; k++) pulse(12, 3);
    pulse(111, 5);
    send_word_fast(24'h5A3C0F);
    chk("hi111 err", n_err, 1);
    chk("hi111 no pix", got_q.size(), 0);
    gap();
    chk("hi111 no done", n_done, 0);
    clear_mon();
    send_word_fast(24'hC0FFEE);
    gap();
    check_frame("after_hi111");

    // 10 bits then gap: truncated pixel
    clear_mon();
    for (int k = 0; k < 10; k++) send_bit_rand(1'($urandom_range(1, 0)));
    gap();
    check_frame("trunc10");

    // Overflow: one pixel more than the frame holds
    clear_mon();
    for (int i = 0; i <= LEDS; i++) send_word_fast(24'h100000 * 24'(i) + 24'h00A5A5);
    gap();
    check_frame("overflow");

    // Mid-frame reset at bit 12 of pixel 2
    clear_mon();
    send_word_fast(24'h123456);
    send_word_fast(24'h89ABCD);
    for (int k = 0; k < 12; k++) send_bit(1'b1, 66, 3);
    chk("pre_rst pix_count", got_q.size(), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst pix_valid", pix_valid, 0);
    chk("midrst pix_addr", pix_addr, 0);
    chk("midrst pix_color", pix_color, 0);
    chk("midrst frame_done", frame_done, 0);
    chk("midrst err", err, 0);
    clear_mon();
    for (int k = 0; k < 12; k++) pulse(12, 3);
    send_word_fast(24'hFEDCBA);
    gap();
    chk("post_rst ignored", got_q.size() + n_done + n_err, 0);
    clear_mon();
    send_word_fast(24'h0F0F0F);
    gap();
    check_frame("after_rst");

    // Random frames with random legal pulse widths
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      npx   = int'($urandom_range(LEDS + 1, 0));
      extra = ($urandom_range(1, 0) == 1) ? int'($urandom_range(23, 1)) : 0;
      if (npx == 0 && extra == 0) extra = 1;
      for (int i = 0; i < npx; i++) begin
        c = 24'($urandom);
        for (int b = 23; b >= 0; b--) send_bit_rand(c[b]);
      end
      for (int k = 0; k < extra; k++) send_bit_rand(1'($urandom_range(1, 0)));
      gap();
      check_frame($sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
